// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: state codes (also decoded by the display
// multiplexor), operand sizing, operator codes (shared with the ALU) and a digit helper.
package calc_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        S_NUM1   = 2'd0,
        S_NUM2   = 2'd1,
        S_CALC   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Append one BCD digit on the right; the leftmost digit falls off.
    function automatic logic [BCD_W-1:0] shift_digit(input logic [BCD_W-1:0] opnd,
                                                     input logic [3:0]       digit);
        return {opnd[BCD_W-5:0], digit};
    endfunction

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector on the keyboard level: one key_evt per press,
// however long the key is held.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_press,
    output logic key_evt
);

    logic btn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) btn_q <= 1'b0;
        else      btn_q <= btn_press;
    end

    assign key_evt = btn_press & ~btn_q;

endmodule

// File: rtl/calc_sequencer.sv
// Turns key events into BCD operands and an operator, then times the capture of the
// combinational ALU result. curr_state exposes the FSM state to the display mux.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_press,
    input  logic             is_num,
    input  logic             is_op,
    input  logic             is_eq,
    input  logic [3:0]       num_val,
    input  logic [1:0]       op_val,
    input  logic [BCD_W-1:0] alu_result,
    output logic [BCD_W-1:0] num1_bcd,
    output logic [BCD_W-1:0] num2_bcd,
    output logic [1:0]       operation,
    output logic [BCD_W-1:0] result_bcd,
    output logic [1:0]       curr_state
);

    localparam int DCW = $clog2(NUM_DIGITS + 1);
    localparam int LCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [DCW-1:0] DIG_FULL  = DCW'(NUM_DIGITS);
    localparam logic [LCW-1:0] LAT_START = LCW'(ALU_LAT - 1);

    state_t           state, state_n;
    logic [BCD_W-1:0] num1, num1_n, num2, num2_n, result, result_n;
    logic [1:0]       op, op_n;
    logic [DCW-1:0]   cnt1, cnt1_n, cnt2, cnt2_n;
    logic [LCW-1:0]   calc_cnt, calc_cnt_n;
    logic             key_evt;
    logic             ev_num, ev_op, ev_eq, digit_ok;

    key_edge u_key_edge (
        .clk       (clk),
        .rst       (rst),
        .btn_press (btn_press),
        .key_evt   (key_evt)
    );

    // Class priority: num > op > eq; an event with no class flag decodes to nothing.
    assign ev_num   = key_evt & is_num;
    assign ev_op    = key_evt & ~is_num & is_op;
    assign ev_eq    = key_evt & ~is_num & ~is_op & is_eq;
    assign digit_ok = (num_val <= 4'd9);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_NUM1;
            num1     <= '0;
            num2     <= '0;
            result   <= '0;
            op       <= OP_ADD;
            cnt1     <= '0;
            cnt2     <= '0;
            calc_cnt <= '0;
        end else begin
            state    <= state_n;
            num1     <= num1_n;
            num2     <= num2_n;
            result   <= result_n;
            op       <= op_n;
            cnt1     <= cnt1_n;
            cnt2     <= cnt2_n;
            calc_cnt <= calc_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        num1_n     = num1;
        num2_n     = num2;
        result_n   = result;
        op_n       = op;
        cnt1_n     = cnt1;
        cnt2_n     = cnt2;
        calc_cnt_n = calc_cnt;
        case (state)
            S_NUM1: begin
                if (ev_num) begin
                    if (digit_ok && cnt1 != DIG_FULL) begin
                        num1_n = shift_digit(num1, num_val);
                        cnt1_n = cnt1 + 1'b1;
                    end
                end else if (ev_op) begin
                    op_n    = op_val;
                    num2_n  = '0;
                    cnt2_n  = '0;
                    state_n = S_NUM2;
                end
            end
            S_NUM2: begin
                if (ev_num) begin
                    if (digit_ok && cnt2 != DIG_FULL) begin
                        num2_n = shift_digit(num2, num_val);
                        cnt2_n = cnt2 + 1'b1;
                    end
                end else if (ev_op) begin
                    op_n = op_val;
                end else if (ev_eq && cnt2 != '0) begin
                    calc_cnt_n = LAT_START;
                    state_n    = S_CALC;
                end
            end
            S_CALC: begin
                // Operands and operator are frozen here so the ALU path can settle.
                if (calc_cnt == '0) begin
                    result_n = alu_result;
                    state_n  = S_RESULT;
                end else begin
                    calc_cnt_n = calc_cnt - 1'b1;
                end
            end
            S_RESULT: begin
                if (ev_num) begin
                    if (digit_ok) begin
                        num1_n   = {{(BCD_W-4){1'b0}}, num_val};
                        cnt1_n   = DCW'(1);
                        num2_n   = '0;
                        cnt2_n   = '0;
                        result_n = '0;
                        state_n  = S_NUM1;
                    end
                end else if (ev_op) begin
                    // A result used as an operand counts as a full entry.
                    num1_n  = result;
                    cnt1_n  = DIG_FULL;
                    op_n    = op_val;
                    num2_n  = '0;
                    cnt2_n  = '0;
                    state_n = S_NUM2;
                end else if (ev_eq) begin
                    num1_n     = result;
                    calc_cnt_n = LAT_START;
                    state_n    = S_CALC;
                end
            end
            default: state_n = S_NUM1;
        endcase
    end

    assign num1_bcd   = num1;
    assign num2_bcd   = num2;
    assign operation  = op;
    assign result_bcd = result;
    assign curr_state = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: one instance with ALU_LAT=1 and one with ALU_LAT=4 share
// the key inputs; captured results are scored against an expected queue per instance.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst4 = 1'b0;
    logic        btn_press = 1'b0;
    logic        is_num = 1'b0;
    logic        is_op = 1'b0;
    logic        is_eq = 1'b0;
    logic [3:0]  num_val = 4'd0;
    logic [1:0]  op_val = 2'd0;
    logic [15:0] alu_result = 16'h0000;

    logic [15:0] num1_bcd, num2_bcd, result_bcd;
    logic [1:0]  operation, curr_state;
    logic [15:0] num1_bcd4, num2_bcd4, result_bcd4;
    logic [1:0]  operation4, curr_state4;

    logic [15:0] exp_q[$];
    logic [15:0] exp4_q[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_sequencer #(.NUM_DIGITS(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .btn_press(btn_press), .is_num(is_num), .is_op(is_op),
        .is_eq(is_eq), .num_val(num_val), .op_val(op_val), .alu_result(alu_result),
        .num1_bcd(num1_bcd), .num2_bcd(num2_bcd), .operation(operation),
        .result_bcd(result_bcd), .curr_state(curr_state)
    );

    calc_sequencer #(.NUM_DIGITS(4), .ALU_LAT(4)) dut4 (
        .clk(clk), .rst(rst4), .btn_press(btn_press), .is_num(is_num), .is_op(is_op),
        .is_eq(is_eq), .num_val(num_val), .op_val(op_val), .alu_result(alu_result),
        .num1_bcd(num1_bcd4), .num2_bcd(num2_bcd4), .operation(operation4),
        .result_bcd(result_bcd4), .curr_state(curr_state4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Key is driven high for 'hold' cycles, then released for at least one edge.
    task automatic press(input logic n, input logic o, input logic e,
                         input logic [3:0] nv, input logic [1:0] ov, input int hold);
        @(negedge clk);
        is_num = n; is_op = o; is_eq = e; num_val = nv; op_val = ov;
        btn_press = 1'b1;
        repeat (hold) @(negedge clk);
        btn_press = 1'b0;
        is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
    endtask

    task automatic press_num(input logic [3:0] v);
        press(1'b1, 1'b0, 1'b0, v, 2'd0, 1);
    endtask

    task automatic press_op(input logic [1:0] v);
        press(1'b0, 1'b1, 1'b0, 4'd0, v, 1);
    endtask

    task automatic press_eq();
        press(1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1);
    endtask

    task automatic reset_both();
        @(negedge clk);
        rst = 1'b0; rst4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; rst4 = 1'b1;
    endtask

    // Result monitors: each entry into RESULT pops one expected value and checks latency.
    logic [1:0] prev_st = 2'd0, prev_st4 = 2'd0;
    int calc_cyc = 0, calc_cyc4 = 0;
    logic [15:0] exp_v, exp_v4;

    always @(negedge clk) begin
        if (curr_state == 2'd2) calc_cyc = (prev_st == 2'd2) ? calc_cyc + 1 : 1;
        if (curr_state == 2'd3 && prev_st != 2'd3) begin
            if (exp_q.size() == 0) begin
                check_val("capture_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_v = exp_q.pop_front();
                check_val("result", result_bcd, exp_v);
                check_val("calc_lat", calc_cyc, 1);
            end
        end
        prev_st = curr_state;
    end

    always @(negedge clk) begin
        if (curr_state4 == 2'd2) calc_cyc4 = (prev_st4 == 2'd2) ? calc_cyc4 + 1 : 1;
        if (curr_state4 == 2'd3 && prev_st4 != 2'd3) begin
            if (exp4_q.size() == 0) begin
                check_val("capture_pending4", 32'(exp4_q.size()), 32'd1);
            end else begin
                exp_v4 = exp4_q.pop_front();
                check_val("result4", result_bcd4, exp_v4);
                check_val("calc_lat4", calc_cyc4, 4);
            end
        end
        prev_st4 = curr_state4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_num1", num1_bcd, 16'h0000);
        check_val("rst_num2", num2_bcd, 16'h0000);
        check_val("rst_res", result_bcd, 16'h0000);
        check_val("rst_op", operation, 2'd0);
        check_val("rst_state", curr_state, 2'd0);
        check_val("rst_state4", curr_state4, 2'd0);
        rst = 1'b1; rst4 = 1'b1;

        // Basic add: 12 + 3
        alu_result = 16'h0015;
        press_num(4'd1);
        check_val("add_state0", curr_state, 2'd0);
        check_val("add_n1a", num1_bcd, 16'h0001);
        press_num(4'd2);
        check_val("add_n1b", num1_bcd, 16'h0012);
        press_op(2'b00);
        check_val("add_state1", curr_state, 2'd1);
        check_val("add_op", operation, 2'b00);
        press_num(4'd3);
        check_val("add_n2", num2_bcd, 16'h0003);
        exp_q.push_back(16'h0015);
        exp4_q.push_back(16'h0015);
        press_eq();
        check_val("add_state2", curr_state, 2'd2);
        check_val("add_state2_4", curr_state4, 2'd2);
        repeat (6) @(negedge clk);
        check_val("add_state3", curr_state, 2'd3);
        check_val("add_n1_keep", num1_bcd, 16'h0012);
        check_val("add_n2_keep", num2_bcd, 16'h0003);
        check_val("add_res4", result_bcd4, 16'h0015);

        // New entry from RESULT
        press_num(4'd9);
        check_val("new_state", curr_state, 2'd0);
        check_val("new_n1", num1_bcd, 16'h0009);
        check_val("new_n2", num2_bcd, 16'h0000);
        check_val("new_res", result_bcd, 16'h0000);

        // Overflow, ignored events, hold
        reset_both();
        for (int i = 1; i <= 5; i++) press_num(4'(i));
        check_val("ovf_n1", num1_bcd, 16'h1234);
        press_eq();
        check_val("eq_num1_state", curr_state, 2'd0);
        check_val("eq_num1_n1", num1_bcd, 16'h1234);
        press_op(2'b10);
        check_val("op_state", curr_state, 2'd1);
        check_val("op_val", operation, 2'b10);
        check_val("op_n2_clr", num2_bcd, 16'h0000);
        press_eq();
        check_val("eq_empty_state", curr_state, 2'd1);
        press_num(4'hA);
        check_val("bad_digit", num2_bcd, 16'h0000);
        press(1'b1, 1'b0, 1'b0, 4'd7, 2'd0, 20);
        check_val("hold_n2", num2_bcd, 16'h0007);
        press(1'b1, 1'b1, 1'b1, 4'd8, 2'd0, 1);
        check_val("prio_n2", num2_bcd, 16'h0078);
        check_val("prio_state", curr_state, 2'd1);
        check_val("prio_op", operation, 2'b10);
        press_op(2'b01);
        check_val("op_replace", operation, 2'b01);
        press(1'b0, 1'b0, 1'b0, 4'd3, 2'd3, 1);
        check_val("noclass_n2", num2_bcd, 16'h0078);
        check_val("noclass_op", operation, 2'b01);
        alu_result = 16'h0042;
        exp_q.push_back(16'h0042);
        exp4_q.push_back(16'h0042);
        press_eq();
        repeat (6) @(negedge clk);
        check_val("ch_state3", curr_state, 2'd3);

        // Chaining: op, then = in RESULT
        press_op(2'b11);
        check_val("ch_n1", num1_bcd, 16'h0042);
        check_val("ch_state1", curr_state, 2'd1);
        check_val("ch_n2", num2_bcd, 16'h0000);
        check_val("ch_op", operation, 2'b11);
        press_num(4'd5);
        press_num(4'd6);
        check_val("ch_full_n2", num2_bcd, 16'h0056);
        alu_result = 16'h0047;
        exp_q.push_back(16'h0047);
        exp4_q.push_back(16'h0047);
        press_eq();
        repeat (6) @(negedge clk);
        alu_result = 16'h0052;
        exp_q.push_back(16'h0052);
        exp4_q.push_back(16'h0052);
        press_eq();
        check_val("rep_state", curr_state, 2'd2);
        check_val("rep_n1", num1_bcd, 16'h0047);
        check_val("rep_n2", num2_bcd, 16'h0056);
        check_val("rep_op", operation, 2'b11);
        repeat (6) @(negedge clk);
        check_val("rep_state3", curr_state, 2'd3);

        // Reset mid-CALC on the ALU_LAT=4 instance
        reset_both();
        press_num(4'd1);
        press_op(2'b00);
        press_num(4'd2);
        alu_result = 16'h0003;
        exp_q.push_back(16'h0003);
        press_eq();
        repeat (2) @(negedge clk);
        check_val("abort_in_calc", curr_state4, 2'd2);
        rst4 = 1'b0;
        #1;
        check_val("abort_state", curr_state4, 2'd0);
        check_val("abort_n1", num1_bcd4, 16'h0000);
        check_val("abort_n2", num2_bcd4, 16'h0000);
        check_val("abort_op", operation4, 2'd0);
        check_val("abort_res", result_bcd4, 16'h0000);
        repeat (2) @(negedge clk);
        rst4 = 1'b1;
        repeat (8) @(negedge clk);
        check_val("abort_after_state", curr_state4, 2'd0);
        check_val("abort_after_res", result_bcd4, 16'h0000);

        check_val("exp_q_left", 32'(exp_q.size()), 32'd0);
        check_val("exp4_q_left", 32'(exp4_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
